// File: rtl/int_pending_ctrl.sv
// -----------------------------------------------------------------------------
// int_pending_ctrl
//
// Interrupt source controller for the core's interrupt unit. It produces the
// 12-bit pending vector (mip bit layout), synchronizes the two asynchronous
// external interrupt lines, runs the 64-bit machine timer (mtime/mtimecmp)
// behind a prescaler, and holds the software-settable pending bits. All state
// is reachable through a small register port with single-cycle writes and
// one-cycle-latency reads.
//
// Parameters:
//   TICK_DIV      core clocks per mtime increment, legal range 1..65535
//
// Ports:
//   i_clk         core clock
//   i_rst_n       asynchronous active-low reset
//   i_meip_async  machine external interrupt line (async, level)
//   i_seip_async  supervisor external interrupt line (async, level)
//   i_wr_en       register write strobe
//   i_rd_en       register read strobe
//   i_addr        register index (0/1 mtime lo/hi, 2/3 mtimecmp lo/hi, 4 swip)
//   i_wdata       write data
//   o_rdata       read data, valid while o_rd_valid is high
//   o_rd_valid    read response, one cycle after i_rd_en
//   o_intp        registered pending vector
//   o_mtime       current mtime register value
// -----------------------------------------------------------------------------
module int_pending_ctrl #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_meip_async,
    input  logic        i_seip_async,
    input  logic        i_wr_en,
    input  logic        i_rd_en,
    input  logic [2:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rd_valid,
    output logic [11:0] o_intp,
    output logic [63:0] o_mtime
);

    localparam logic [15:0] PRE_LAST  = 16'(TICK_DIV - 1);
    // Writable swip bits: SEIP_sw(9), STIP(5), MSIP(3), SSIP(1).
    localparam logic [31:0] SWIP_MASK = 32'h0000_022A;

    logic        meip_meta;
    logic        meip_s;
    logic        seip_meta;
    logic        seip_s;
    logic [15:0] pre;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] swip;
    logic        mtip;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic [31:0] rd_mux;

    assign tick        = (pre == PRE_LAST);
    assign wr_mtime_lo = i_wr_en && (i_addr == 3'd0);
    assign wr_mtime_hi = i_wr_en && (i_addr == 3'd1);
    assign o_mtime     = mtime;

    // Two-flop synchronizers; plain level following, no edge capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meip_meta <= 1'b0;
            meip_s    <= 1'b0;
            seip_meta <= 1'b0;
            seip_s    <= 1'b0;
        end else begin
            meip_meta <= i_meip_async;
            meip_s    <= meip_meta;
            seip_meta <= i_seip_async;
            seip_s    <= seip_meta;
        end
    end

    // Prescaler and mtime. A software write to either mtime half wins over
    // the tick for the whole counter (no increment, no carry into the other
    // half) and restarts the prescaler so the next tick is a full period away.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre   <= '0;
            mtime <= '0;
        end else begin
            if (wr_mtime_lo || wr_mtime_hi) begin
                pre <= '0;
                if (wr_mtime_lo) mtime[31:0]  <= i_wdata;
                if (wr_mtime_hi) mtime[63:32] <= i_wdata;
            end else if (tick) begin
                pre   <= '0;
                mtime <= mtime + 64'd1;
            end else begin
                pre <= pre + 16'd1;
            end
        end
    end

    // mtimecmp and software pending bits. mtimecmp resets to all ones so
    // the timer interrupt stays quiet until software programs it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtimecmp <= '1;
            swip     <= '0;
        end else if (i_wr_en) begin
            case (i_addr)
                3'd2:    mtimecmp[31:0]  <= i_wdata;
                3'd3:    mtimecmp[63:32] <= i_wdata;
                3'd4:    swip            <= i_wdata & SWIP_MASK;
                default: ;
            endcase
        end
    end

    // mtip compares the register values, i.e. the results of the previous
    // cycle's updates; o_intp adds one more register stage on top.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtip   <= 1'b0;
            o_intp <= '0;
        end else begin
            mtip   <= (mtime >= mtimecmp);
            o_intp <= {meip_s, 1'b0, seip_s | swip[9], 1'b0,
                       mtip,   1'b0, swip[5],          1'b0,
                       swip[3], 1'b0, swip[1],         1'b0};
        end
    end

    // Read mux sees the pre-write register values, so a same-cycle
    // read/write of one address returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (i_addr)
            3'd0:    rd_mux = mtime[31:0];
            3'd1:    rd_mux = mtime[63:32];
            3'd2:    rd_mux = mtimecmp[31:0];
            3'd3:    rd_mux = mtimecmp[63:32];
            3'd4:    rd_mux = swip;
            default: rd_mux = '0;
        endcase
    end

    // Read response register: one pulse per cycle of i_rd_en, data held
    // between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata    <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_en;
            if (i_rd_en) o_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_int_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_pending_ctrl
//
// Self-checking bench for int_pending_ctrl. Two instances share all inputs:
// dut1 with TICK_DIV = 1 and dut4 with TICK_DIV = 4. A table of register
// write/readback vectors covers the register map and software pending bits;
// hand-written sequences cover reset, timer hit/clear, prescaler wrap,
// synchronizer latency, read/write collision and reset during a read.
// -----------------------------------------------------------------------------
module tb_int_pending_ctrl;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [11:0] exp_intp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        meip_async;
    logic        seip_async;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [31:0] wdata;

    logic [31:0] rdata1;
    logic        rd_valid1;
    logic [11:0] intp1;
    logic [63:0] mtime1;
    logic [31:0] rdata4;
    logic        rd_valid4;
    logic [11:0] intp4;
    logic [63:0] mtime4;

    int tests_run;
    int tests_failed;

    vec_t vecs [11];

    int_pending_ctrl #(.TICK_DIV(1)) dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_meip_async (meip_async),
        .i_seip_async (seip_async),
        .i_wr_en      (wr_en),
        .i_rd_en      (rd_en),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata1),
        .o_rd_valid   (rd_valid1),
        .o_intp       (intp1),
        .o_mtime      (mtime1)
    );

    int_pending_ctrl #(.TICK_DIV(4)) dut4 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_meip_async (meip_async),
        .i_seip_async (seip_async),
        .i_wr_en      (wr_en),
        .i_rd_en      (rd_en),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata4),
        .o_rd_valid   (rd_valid4),
        .o_intp       (intp4),
        .o_mtime      (mtime4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        addr  = a;
        step();
        rd_en = 1'b0;
        checkOutput("rd_valid", {63'd0, rd_valid1}, 64'd1);
        d = rdata1;
    endtask

    // Write one vector, then read it back; the read edge is also the edge
    // on which a swip change reaches o_intp.
    task automatic applyStimulus(input vec_t v, input int idx);
        logic [31:0] rd;
        write_reg(v.addr, v.wdata);
        read_reg(v.addr, rd);
        checkOutput($sformatf("vec%0d rdata", idx), {32'd0, rd}, {32'd0, v.exp_rd});
        checkOutput($sformatf("vec%0d intp", idx), {52'd0, intp1}, {52'd0, v.exp_intp});
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        meip_async   = 1'b0;
        seip_async   = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        addr         = 3'd0;
        wdata        = 32'd0;

        // cmp hi is raised to 1 before cmp lo becomes small, so mtip never
        // fires while the table runs.
        vecs[0]  = '{3'd4, 32'h0000_022A, 32'h0000_022A, 12'h22A};
        vecs[1]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_022A, 12'h22A};
        vecs[2]  = '{3'd4, 32'h0000_0008, 32'h0000_0008, 12'h008};
        vecs[3]  = '{3'd4, 32'h0000_0202, 32'h0000_0202, 12'h202};
        vecs[4]  = '{3'd4, 32'hFFFF_FDD5, 32'h0000_0000, 12'h000};
        vecs[5]  = '{3'd3, 32'h0000_0001, 32'h0000_0001, 12'h000};
        vecs[6]  = '{3'd2, 32'h1234_5678, 32'h1234_5678, 12'h000};
        vecs[7]  = '{3'd5, 32'hDEAD_BEEF, 32'h0000_0000, 12'h000};
        vecs[8]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 12'h000};
        vecs[9]  = '{3'd4, 32'h0000_0020, 32'h0000_0020, 12'h020};
        vecs[10] = '{3'd4, 32'h0000_0000, 32'h0000_0000, 12'h000};

        // ---------------- reset state ----------------
        step();
        step();
        checkOutput("reset mtime", mtime1, 64'd0);
        checkOutput("reset rd_valid", {63'd0, rd_valid1}, 64'd0);
        checkOutput("reset intp", {52'd0, intp1}, 64'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("mtime count %0d", k), mtime1, 64'(k));
        end
        checkOutput("intp after reset", {52'd0, intp1}, 64'd0);
        read_reg(3'd2, rd);
        checkOutput("reset mtimecmp lo", {32'd0, rd}, 64'hFFFF_FFFF);
        read_reg(3'd3, rd);
        checkOutput("reset mtimecmp hi", {32'd0, rd}, 64'hFFFF_FFFF);

        // ---------------- register / swip table ----------------
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        // ---------------- timer hit and clear ----------------
        write_reg(3'd0, 32'd0);
        write_reg(3'd1, 32'd0);
        write_reg(3'd3, 32'd0);
        write_reg(3'd2, 32'd100);
        cnt = 0;
        while (mtime1 != 64'd100 && cnt < 300) begin
            step();
            cnt++;
        end
        checkOutput("mtime reached 100", mtime1, 64'd100);
        checkOutput("mtip edge n", {63'd0, intp1[7]}, 64'd0);
        step();
        checkOutput("mtip edge n+1", {63'd0, intp1[7]}, 64'd0);
        step();
        checkOutput("mtip edge n+2", {63'd0, intp1[7]}, 64'd1);
        write_reg(3'd2, 32'hFFFF_FFFF);
        checkOutput("mtip clear m", {63'd0, intp1[7]}, 64'd1);
        step();
        checkOutput("mtip clear m+1", {63'd0, intp1[7]}, 64'd1);
        step();
        checkOutput("mtip clear m+2", {63'd0, intp1[7]}, 64'd0);

        // ---------------- external line synchronization ----------------
        meip_async = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            checkOutput($sformatf("meip k=%0d", k), {63'd0, intp1[11]},
                        (k >= 2 && k <= 6) ? 64'd1 : 64'd0);
            if (k == 4) meip_async = 1'b0;
        end
        write_reg(3'd4, 32'h0000_0200);
        step();
        checkOutput("seip_sw intp", {52'd0, intp1}, 64'h200);
        seip_async = 1'b1;
        repeat (4) step();
        write_reg(3'd4, 32'd0);
        repeat (3) step();
        checkOutput("seip line intp", {52'd0, intp1}, 64'h200);
        seip_async = 1'b0;
        repeat (4) step();
        checkOutput("seip released", {52'd0, intp1}, 64'h000);

        // ---------------- read/write collision ----------------
        rd_en = 1'b1;
        wr_en = 1'b1;
        addr  = 3'd2;
        wdata = 32'hAAAA_5555;
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
        checkOutput("collision valid", {63'd0, rd_valid1}, 64'd1);
        checkOutput("collision old value", {32'd0, rdata1}, 64'hFFFF_FFFF);
        read_reg(3'd2, rd);
        checkOutput("collision new value", {32'd0, rd}, 64'hAAAA_5555);
        rd_en = 1'b1;
        addr  = 3'd4;
        step();
        checkOutput("back-to-back 1", {63'd0, rd_valid1}, 64'd1);
        step();
        rd_en = 1'b0;
        checkOutput("back-to-back 2", {63'd0, rd_valid1}, 64'd1);
        step();
        checkOutput("read pulse ends", {63'd0, rd_valid1}, 64'd0);

        // ---------------- prescaler, wrap, write coincident with tick ----------------
        write_reg(3'd0, 32'hFFFF_FFFE);
        write_reg(3'd1, 32'hFFFF_FFFF);
        repeat (7) step();
        checkOutput("div4 before wrap", mtime4, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        checkOutput("div4 wrapped", mtime4, 64'd0);
        repeat (3) step();
        write_reg(3'd0, 32'h0000_0050);
        checkOutput("div4 write on tick", mtime4, 64'h50);
        repeat (3) step();
        checkOutput("div4 hold after write", mtime4, 64'h50);
        step();
        checkOutput("div4 next tick", mtime4, 64'h51);
        write_reg(3'd0, 32'h0000_1234);
        checkOutput("div1 write on tick", {32'd0, mtime1[31:0]}, 64'h1234);
        step();
        checkOutput("div1 after write", {32'd0, mtime1[31:0]}, 64'h1235);

        // ---------------- reset during a read ----------------
        write_reg(3'd4, 32'h0000_022A);
        rd_en = 1'b1;
        addr  = 3'd2;
        step();
        rd_en = 1'b0;
        checkOutput("pre-reset valid", {63'd0, rd_valid1}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-read rd_valid", {63'd0, rd_valid1}, 64'd0);
        checkOutput("mid-read rdata", {32'd0, rdata1}, 64'd0);
        checkOutput("mid-read intp", {52'd0, intp1}, 64'd0);
        checkOutput("mid-read mtime1", mtime1, 64'd0);
        checkOutput("mid-read mtime4", mtime4, 64'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checkOutput($sformatf("no late pulse %0d", k), {63'd0, rd_valid1}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
